// File: rtl/quad_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quad_dec_pkg
//  Brief    : Shared constants, state encoding and step decoder for the
//             multi-channel quadrature decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package quad_dec_pkg;

  // Config write bit positions within wr_data
  localparam int CFG_CLR = 0;
  localparam int CFG_SAT = 1;
  localparam int CFG_X1  = 2;
  localparam int CFG_IE  = 3;

  // Read word fields sit above the count; offsets are relative to CNT_W
  localparam int RD_SW_OFS  = 0;
  localparam int RD_EVT_OFS = 2;
  localparam int RD_ERR_OFS = 3;

  // Per-channel start-up state
  typedef enum logic [0:0] {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } ch_state_t;

  // Direction of one {B,A} step
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2,
    DIR_ILL  = 2'd3
  } dir_t;

  // Position of a {B,A} level along the forward cycle 00,01,11,10
  function automatic logic [1:0] gray_pos(input logic [1:0] ba);
    logic [1:0] p;
    case (ba)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Distance around the cycle tells the direction; two positions away is illegal
  function automatic dir_t step_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    dir_t       r;
    d = gray_pos(cur) - gray_pos(prev);
    case (d)
      2'd0:    r = DIR_NONE;
      2'd1:    r = DIR_INC;
      2'd3:    r = DIR_DEC;
      default: r = DIR_ILL;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_dec_ch.sv
`default_nettype none
// ============================================================================
//  Module   : quad_dec_ch
//  Brief    : One encoder channel: input synchroniser, glitch filter, arming
//             FSM, X4/X1 step decode, wrap/saturate counter and sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_dec_ch
  import quad_dec_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int CNT_INIT = 128,
  parameter int FILT_LEN = 4
) (
  input  logic             clk_62p5mhz,
  input  logic             reset_,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic [1:0]       enc_sw,
  input  logic             wr_stb,
  input  logic [3:0]       wr_data,
  input  logic             rd_stb,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       sw,
  output logic             evt,
  output logic             err,
  output logic             ie
);

  localparam logic [3:0]       c_filt = 4'(FILT_LEN);
  localparam logic [CNT_W-1:0] c_init = CNT_W'(CNT_INIT);
  localparam logic [CNT_W-1:0] c_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  // Input bit order everywhere below: {sw1, sw0, b, a}
  logic [3:0]       r_sync1, r_sync2, r_filt;
  logic [3:0][3:0]  r_fcnt;
  logic [3:0]       r_arm_cnt;
  ch_state_t        r_state, w_state_nxt;
  logic             w_arm_load;
  logic [1:0]       r_prev, w_cur;
  dir_t             w_dir;
  logic             w_run, w_inc, w_dec, w_ill, w_clr, w_step;
  logic             r_sat, r_x1, r_ie, r_evt, r_err;
  logic [CNT_W-1:0] r_count;

  // Two-flop synchroniser on all raw inputs
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {enc_sw, enc_b, enc_a};
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: a new level must persist FILT_LEN samples to be accepted
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      r_fcnt <= '0;
      r_filt <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (r_sync2[j] == r_filt[j]) begin
          r_fcnt[j] <= '0;
        end else if (r_fcnt[j] == c_filt - 4'd1) begin
          r_filt[j] <= r_sync2[j];
          r_fcnt[j] <= '0;
        end else begin
          r_fcnt[j] <= r_fcnt[j] + 4'd1;
        end
      end
    end
  end

  // Start-up timer: saturates once FILT_LEN cycles have elapsed since reset
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_)                 r_arm_cnt <= '0;
    else if (r_arm_cnt != c_filt) r_arm_cnt <= r_arm_cnt + 4'd1;
  end

  // FSM state register
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) r_state <= ST_ARM;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: arm once the A/B filters are quiet and start-up time is over
  always_comb begin
    w_state_nxt = r_state;
    w_arm_load  = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (r_arm_cnt == c_filt && r_fcnt[0] == 4'd0 && r_fcnt[1] == 4'd0) begin
          w_state_nxt = ST_RUN;
          w_arm_load  = 1'b1;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // Step decode; X1 only counts the transitions that land on 00
  always_comb begin
    w_cur  = r_filt[1:0];
    w_run  = (r_state == ST_RUN);
    w_dir  = step_dir(r_prev, w_cur);
    w_inc  = w_run && (w_dir == DIR_INC) && (!r_x1 || (r_prev == 2'b10 && w_cur == 2'b00));
    w_dec  = w_run && (w_dir == DIR_DEC) && (!r_x1 || (r_prev == 2'b01 && w_cur == 2'b00));
    w_ill  = w_run && (w_dir == DIR_ILL);
    w_step = w_inc || w_dec;
    w_clr  = wr_stb && wr_data[CFG_CLR];
  end

  // Previous {B,A}: loaded on arming, then follows the filtered level
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_)                r_prev <= '0;
    else if (w_arm_load || w_run) r_prev <= w_cur;
  end

  // Channel configuration
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      r_sat <= 1'b0;
      r_x1  <= 1'b0;
      r_ie  <= 1'b0;
    end else if (wr_stb) begin
      r_sat <= wr_data[CFG_SAT];
      r_x1  <= wr_data[CFG_X1];
      r_ie  <= wr_data[CFG_IE];
    end
  end

  // Position counter; clear beats a coincident step
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      r_count <= c_init;
    end else if (w_clr) begin
      r_count <= c_init;
    end else if (w_inc) begin
      if (!(r_sat && r_count == c_max)) r_count <= r_count + c_one;
    end else if (w_dec) begin
      if (!(r_sat && r_count == '0)) r_count <= r_count - c_one;
    end
  end

  // Sticky flags: clear > set > read-clear
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) begin
      r_evt <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_clr)       r_evt <= 1'b0;
      else if (w_step) r_evt <= 1'b1;
      else if (rd_stb) r_evt <= 1'b0;
      if (w_clr)       r_err <= 1'b0;
      else if (w_ill)  r_err <= 1'b1;
      else if (rd_stb) r_err <= 1'b0;
    end
  end

  assign count = r_count;
  assign sw    = r_filt[3:2];
  assign evt   = r_evt;
  assign err   = r_err;
  assign ie    = r_ie;

endmodule
`default_nettype wire

// File: rtl/quad_dec_array.sv
`default_nettype none
// ============================================================================
//  Module   : quad_dec_array
//  Brief    : NCH-channel quadrature decoder with a channel-indexed
//             config/read port, live counter bus and shared interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_dec_array
  import quad_dec_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 8,
  parameter int CNT_INIT = 128,
  parameter int FILT_LEN = 4,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk_62p5mhz,
  input  logic                 reset_,
  input  logic [NCH-1:0]       enc_a,
  input  logic [NCH-1:0]       enc_b,
  input  logic [2*NCH-1:0]     enc_sw,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic                 wr_en,
  input  logic [3:0]           wr_data,
  input  logic                 rd_en,
  output logic [CNT_W+3:0]     rd_data,
  output logic [NCH*CNT_W-1:0] cnt_flat,
  output logic                 irq
);

  logic [CNT_W-1:0] w_count [NCH];
  logic [1:0]       w_sw    [NCH];
  logic [NCH-1:0]   w_evt, w_err, w_ie, w_wr, w_rd;
  logic [CNT_W+3:0] w_rd_word;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range ch_sel matches no channel, so its strobes go nowhere
    assign w_wr[i] = wr_en && (ch_sel == CH_W'(i));
    assign w_rd[i] = rd_en && (ch_sel == CH_W'(i));

    quad_dec_ch #(
      .CNT_W    (CNT_W),
      .CNT_INIT (CNT_INIT),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk_62p5mhz (clk_62p5mhz),
      .reset_      (reset_),
      .enc_a       (enc_a[i]),
      .enc_b       (enc_b[i]),
      .enc_sw      (enc_sw[2*i +: 2]),
      .wr_stb      (w_wr[i]),
      .wr_data     (wr_data),
      .rd_stb      (w_rd[i]),
      .count       (w_count[i]),
      .sw          (w_sw[i]),
      .evt         (w_evt[i]),
      .err         (w_err[i]),
      .ie          (w_ie[i])
    );

    assign cnt_flat[i*CNT_W +: CNT_W] = w_count[i];
  end

  // Read word mux; an unmatched channel index yields zero
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        w_rd_word[CNT_W-1:0]              = w_count[i];
        w_rd_word[CNT_W+RD_SW_OFS +: 2]   = w_sw[i];
        w_rd_word[CNT_W+RD_EVT_OFS]       = w_evt[i];
        w_rd_word[CNT_W+RD_ERR_OFS]       = w_err[i];
      end
    end
  end

  // Registered read port: snapshot of the selected channel, held between reads
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_)    rd_data <= '0;
    else if (rd_en) rd_data <= w_rd_word;
  end

  // Interrupt: any channel with an enabled pending event
  always_ff @(posedge clk_62p5mhz or negedge reset_) begin
    if (!reset_) irq <= 1'b0;
    else         irq <= |(w_evt & w_ie);
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_dec_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_quad_dec_array
//  Brief    : Self-checking bench for quad_dec_array against a behavioural
//             position/flag model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quad_dec_array;

  localparam int NCH      = 3;
  localparam int CNT_W    = 8;
  localparam int CNT_INIT = 128;
  localparam int FILT_LEN = 4;
  localparam int CH_W     = 2;
  localparam int HOLD     = 10;
  localparam int LAT      = FILT_LEN + 3;

  logic                 clk_62p5mhz = 1'b0;
  logic                 reset_;
  logic [NCH-1:0]       enc_a, enc_b;
  logic [2*NCH-1:0]     enc_sw;
  logic [CH_W-1:0]      ch_sel;
  logic                 wr_en, rd_en;
  logic [3:0]           wr_data;
  logic [CNT_W+3:0]     rd_data;
  logic [NCH*CNT_W-1:0] cnt_flat;
  logic                 irq;

  int n_cmp  = 0;
  int n_fail = 0;

  quad_dec_array #(
    .NCH(NCH), .CNT_W(CNT_W), .CNT_INIT(CNT_INIT), .FILT_LEN(FILT_LEN), .CH_W(CH_W)
  ) dut (
    .clk_62p5mhz (clk_62p5mhz),
    .reset_      (reset_),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .enc_sw      (enc_sw),
    .ch_sel      (ch_sel),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .cnt_flat    (cnt_flat),
    .irq         (irq)
  );

  always #8 clk_62p5mhz = ~clk_62p5mhz;

  // ---------------- behavioural model ----------------
  int         m_cnt [NCH];
  bit         m_evt [NCH], m_err [NCH], m_sat [NCH], m_x1 [NCH], m_ie [NCH];
  logic [1:0] m_ba  [NCH];

  // Forward rotation visits 00,01,11,10
  function automatic int qpos(input logic [1:0] ba);
    case (ba)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] qlevel(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic void m_reset(input logic [1:0] ba);
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = CNT_INIT; m_evt[c] = 0; m_err[c] = 0;
      m_sat[c] = 0; m_x1[c] = 0; m_ie[c] = 0; m_ba[c] = ba;
    end
  endfunction

  function automatic void m_move(input int c, input logic [1:0] nb);
    int d;
    d = (qpos(nb) - qpos(m_ba[c]) + 4) % 4;
    if (d == 2) begin
      m_err[c] = 1;
    end else if (d == 1 && (!m_x1[c] || nb == 2'b00)) begin
      m_evt[c] = 1;
      if (m_sat[c]) m_cnt[c] = (m_cnt[c] == 255) ? 255 : m_cnt[c] + 1;
      else          m_cnt[c] = (m_cnt[c] + 1) % 256;
    end else if (d == 3 && (!m_x1[c] || nb == 2'b00)) begin
      m_evt[c] = 1;
      if (m_sat[c]) m_cnt[c] = (m_cnt[c] == 0) ? 0 : m_cnt[c] - 1;
      else          m_cnt[c] = (m_cnt[c] + 255) % 256;
    end
    m_ba[c] = nb;
  endfunction

  function automatic void m_write(input int sel, input logic [3:0] d);
    if (sel < NCH) begin
      m_sat[sel] = d[1]; m_x1[sel] = d[2]; m_ie[sel] = d[3];
      if (d[0]) begin m_cnt[sel] = CNT_INIT; m_evt[sel] = 0; m_err[sel] = 0; end
    end
  endfunction

  // Expected read word; reading clears the channel's flags
  function automatic logic [CNT_W+3:0] m_read(input int sel);
    logic [CNT_W+3:0] v;
    v = '0;
    if (sel < NCH) begin
      v = {m_err[sel], m_evt[sel], enc_sw[2*sel +: 2], CNT_W'(m_cnt[sel])};
      m_evt[sel] = 0; m_err[sel] = 0;
    end
    return v;
  endfunction

  function automatic logic [NCH*CNT_W-1:0] exp_flat();
    logic [NCH*CNT_W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    return v;
  endfunction

  function automatic logic exp_irq();
    logic v;
    v = 1'b0;
    for (int c = 0; c < NCH; c++) v = v | (m_evt[c] & m_ie[c]);
    return v;
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic set_ba(input int c, input logic [1:0] nb);
    enc_a[c] = nb[0]; enc_b[c] = nb[1];
    m_move(c, nb);
  endtask

  task automatic do_read(input int sel);
    ch_sel = CH_W'(sel); rd_en = 1'b1;
    @(negedge clk_62p5mhz);
    rd_en = 1'b0;
  endtask

  task automatic do_write(input int sel, input logic [3:0] d);
    ch_sel = CH_W'(sel); wr_data = d; wr_en = 1'b1;
    @(negedge clk_62p5mhz);
    wr_en = 1'b0;
    m_write(sel, d);
  endtask

  task automatic apply_reset(input logic [1:0] ba);
    reset_ = 1'b0;
    enc_a = {NCH{ba[0]}}; enc_b = {NCH{ba[1]}};
    m_reset(ba);
    repeat (3) @(negedge clk_62p5mhz);
    reset_ = 1'b1;
    repeat (20) @(negedge clk_62p5mhz);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [CNT_W+3:0] exp;
    wr_en = 0; rd_en = 0; ch_sel = '0; wr_data = '0; enc_sw = '0;
    apply_reset(2'b11);
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL reset_cnt: got %h want %h", cnt_flat, exp_flat()); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL reset_arm_rd: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_x4_latency();
    logic [1:0] fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rev [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    apply_reset(2'b00);
    set_ba(0, fwd[0]);
    repeat (LAT - 1) @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat[0 +: CNT_W] !== 8'd128) begin n_fail++; $display("FAIL lat_early: got %0d want 128", cnt_flat[0 +: CNT_W]); end
    @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat[0 +: CNT_W] !== 8'd129) begin n_fail++; $display("FAIL lat_exact: got %0d want 129", cnt_flat[0 +: CNT_W]); end
    repeat (HOLD) @(negedge clk_62p5mhz);
    for (int k = 1; k < 4; k++) begin
      set_ba(0, fwd[k]);
      repeat (HOLD) @(negedge clk_62p5mhz);
      n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL x4_fwd%0d: got %h want %h", k, cnt_flat, exp_flat()); end
    end
    n_cmp++; if (cnt_flat[0 +: CNT_W] !== 8'd132) begin n_fail++; $display("FAIL x4_fwd_total: got %0d want 132", cnt_flat[0 +: CNT_W]); end
    for (int k = 0; k < 4; k++) begin
      set_ba(0, rev[k]);
      repeat (HOLD) @(negedge clk_62p5mhz);
      n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL x4_rev%0d: got %h want %h", k, cnt_flat, exp_flat()); end
    end
    n_cmp++; if (cnt_flat[0 +: CNT_W] !== 8'd128) begin n_fail++; $display("FAIL x4_rev_total: got %0d want 128", cnt_flat[0 +: CNT_W]); end
  endtask

  task automatic test_glitch_illegal();
    logic [CNT_W+3:0] exp;
    // Pulse one cycle shorter than the filter length
    enc_a[0] = 1'b1;
    repeat (FILT_LEN - 1) @(negedge clk_62p5mhz);
    enc_a[0] = 1'b0;
    repeat (HOLD + 5) @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL glitch: got %h want %h", cnt_flat, exp_flat()); end
    set_ba(0, 2'b11);
    repeat (HOLD) @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL illegal_cnt: got %h want %h", cnt_flat, exp_flat()); end
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data[CNT_W+3] !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", rd_data[CNT_W+3]); end
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL illegal_rd: got %h want %h", rd_data, exp); end
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL err_cleared_rd: got %h want %h", rd_data, exp); end
    set_ba(0, 2'b10); repeat (HOLD) @(negedge clk_62p5mhz);
    set_ba(0, 2'b00); repeat (HOLD) @(negedge clk_62p5mhz);
  endtask

  task automatic test_x1_sat();
    logic [1:0]       fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [CNT_W+3:0] exp;
    do_write(1, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      set_ba(1, fwd[k]);
      repeat (HOLD) @(negedge clk_62p5mhz);
      n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL x1_step%0d: got %h want %h", k, cnt_flat, exp_flat()); end
    end
    n_cmp++; if (cnt_flat[CNT_W +: CNT_W] !== 8'd129) begin n_fail++; $display("FAIL x1_total: got %0d want 129", cnt_flat[CNT_W +: CNT_W]); end
    do_write(1, 4'b0011);
    @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat[CNT_W +: CNT_W] !== 8'd128) begin n_fail++; $display("FAIL sat_clear: got %0d want 128", cnt_flat[CNT_W +: CNT_W]); end
    for (int k = 0; k < 127; k++) begin
      set_ba(1, qlevel(qpos(m_ba[1]) + 1));
      repeat (8) @(negedge clk_62p5mhz);
    end
    n_cmp++; if (cnt_flat[CNT_W +: CNT_W] !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d want 255", cnt_flat[CNT_W +: CNT_W]); end
    exp = m_read(1);
    do_read(1);
    for (int k = 0; k < 3; k++) begin
      set_ba(1, qlevel(qpos(m_ba[1]) + 1));
      repeat (8) @(negedge clk_62p5mhz);
    end
    n_cmp++; if (cnt_flat[CNT_W +: CNT_W] !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", cnt_flat[CNT_W +: CNT_W]); end
    exp = m_read(1);
    do_read(1);
    n_cmp++; if (rd_data[CNT_W+2] !== 1'b1) begin n_fail++; $display("FAIL sat_evt: got %b want 1", rd_data[CNT_W+2]); end
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL sat_rd: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_wrap();
    do_write(2, 4'b0001);
    for (int k = 0; k < 129; k++) begin
      set_ba(2, qlevel(qpos(m_ba[2]) + 3));
      repeat (8) @(negedge clk_62p5mhz);
    end
    n_cmp++; if (cnt_flat[2*CNT_W +: CNT_W] !== 8'd255) begin n_fail++; $display("FAIL wrap_down: got %0d want 255", cnt_flat[2*CNT_W +: CNT_W]); end
    set_ba(2, qlevel(qpos(m_ba[2]) + 1));
    repeat (HOLD) @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat[2*CNT_W +: CNT_W] !== 8'd0) begin n_fail++; $display("FAIL wrap_up: got %0d want 0", cnt_flat[2*CNT_W +: CNT_W]); end
  endtask

  task automatic test_irq();
    logic [CNT_W+3:0] exp;
    logic [1:0]       nb;
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL irq_pre_rd: got %h want %h", rd_data, exp); end
    do_write(0, 4'b1000);
    set_ba(0, qlevel(qpos(m_ba[0]) + 1));
    repeat (HOLD) @(negedge clk_62p5mhz);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    // Step lands on the same edge as the read strobe
    nb = qlevel(qpos(m_ba[0]) + 1);
    enc_a[0] = nb[0]; enc_b[0] = nb[1];
    repeat (LAT - 1) @(negedge clk_62p5mhz);
    exp = m_read(0);
    m_move(0, nb);
    do_read(0);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL rd_step_rd: got %h want %h", rd_data, exp); end
    repeat (2) @(negedge clk_62p5mhz);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rd_step_irq: got %b want 1", irq); end
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data[CNT_W+2] !== 1'b1) begin n_fail++; $display("FAIL rd_step_evt: got %b want 1", rd_data[CNT_W+2]); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag: got %b want 1", irq); end
    @(negedge clk_62p5mhz);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", irq); end
  endtask

  task automatic test_oob_and_clear();
    logic [CNT_W+3:0] exp;
    logic [1:0]       nb;
    do_write(3, 4'b0001);
    @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL oob_wr: got %h want %h", cnt_flat, exp_flat()); end
    do_read(3);
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL oob_rd: got %h want 0", rd_data); end
    // Read and clearing write on the same cycle
    exp = m_read(1);
    ch_sel = 2'd1; rd_en = 1'b1; wr_en = 1'b1; wr_data = 4'b0001;
    @(negedge clk_62p5mhz);
    rd_en = 1'b0; wr_en = 1'b0;
    m_write(1, 4'b0001);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL rdwr_rd: got %h want %h", rd_data, exp); end
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL rdwr_cnt: got %h want %h", cnt_flat, exp_flat()); end
    // Clear coinciding with a counted step
    nb = qlevel(qpos(m_ba[0]) + 1);
    enc_a[0] = nb[0]; enc_b[0] = nb[1];
    m_move(0, nb);
    repeat (LAT - 1) @(negedge clk_62p5mhz);
    do_write(0, 4'b1001);
    repeat (2) @(negedge clk_62p5mhz);
    n_cmp++; if (cnt_flat[0 +: CNT_W] !== 8'd128) begin n_fail++; $display("FAIL clr_step_cnt: got %0d want 128", cnt_flat[0 +: CNT_W]); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_step_irq: got %b want 0", irq); end
    exp = m_read(0);
    do_read(0);
    n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL clr_step_rd: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_reset_midop();
    set_ba(1, qlevel(qpos(m_ba[1]) + 1));
    repeat (HOLD) @(negedge clk_62p5mhz);
    reset_ = 1'b0;
    m_reset(2'b00);
    #1;
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL async_rst_cnt: got %h want %h", cnt_flat, exp_flat()); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL async_rst_rd: got %h want 0", rd_data); end
    apply_reset(2'b00);
    n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL rearm_cnt: got %h want %h", cnt_flat, exp_flat()); end
  endtask

  task automatic test_random();
    logic [CNT_W+3:0] exp;
    int               k, sel;
    for (int r = 0; r < 150; r++) begin
      for (int c = 0; c < NCH; c++) begin
        k = $urandom_range(0, 9);
        if (k < 4)       set_ba(c, qlevel(qpos(m_ba[c]) + 1));
        else if (k < 8)  set_ba(c, qlevel(qpos(m_ba[c]) + 3));
        else if (k == 9) set_ba(c, qlevel(qpos(m_ba[c]) + 2));
      end
      enc_sw = ($urandom & 32'h3f) % 64;
      repeat (HOLD) @(negedge clk_62p5mhz);
      n_cmp++; if (cnt_flat !== exp_flat()) begin n_fail++; $display("FAIL rnd_cnt r%0d: got %h want %h", r, cnt_flat, exp_flat()); end
      n_cmp++; if (irq !== exp_irq()) begin n_fail++; $display("FAIL rnd_irq r%0d: got %b want %b", r, irq, exp_irq()); end
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 3);
        exp = m_read(sel);
        do_read(sel);
        n_cmp++; if (rd_data !== exp) begin n_fail++; $display("FAIL rnd_rd r%0d ch%0d: got %h want %h", r, sel, rd_data, exp); end
      end
      if ($urandom_range(0, 5) == 0) do_write($urandom_range(0, 3), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_x4_latency();
    test_glitch_illegal();
    test_x1_sat();
    test_wrap();
    test_irq();
    test_oob_and_clear();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
